// File: rtl/knight_pkg.sv
// Shared constants for the knight's-tour command path: cmd_proc opcodes, headings,
// response bytes and the sequencer state encoding.
package knight_pkg;

  localparam int NUM_MOVES_DEFAULT = 24;

  localparam logic [3:0] OP_MOVE         = 4'h2;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] ACK     = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Turns a one-hot knight move into its two cmd_proc legs: a plain vertical MOVE
// followed by a horizontal MOVE_FANFARE. valid is low unless exactly one bit is set.
module tour_move_decode
  import knight_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        valid
);

  localparam logic [7:0] VERT_HDG [8] = '{HDG_N, HDG_N, HDG_N, HDG_S, HDG_S, HDG_S, HDG_S, HDG_N};
  localparam logic [3:0] VERT_SQ  [8] = '{4'd2,  4'd2,  4'd1,  4'd1,  4'd2,  4'd2,  4'd1,  4'd1};
  localparam logic [7:0] HORZ_HDG [8] = '{HDG_E, HDG_W, HDG_W, HDG_W, HDG_W, HDG_E, HDG_E, HDG_E};
  localparam logic [3:0] HORZ_SQ  [8] = '{4'd1,  4'd1,  4'd2,  4'd2,  4'd1,  4'd1,  4'd2,  4'd2};

  // OR of per-bit terms: exact for one-hot input, don't-care otherwise (valid is low).
  always_comb begin
    vert_cmd = 16'h0000;
    horz_cmd = 16'h0000;
    for (int b = 0; b < 8; b++) begin
      if (move[b]) begin
        vert_cmd = vert_cmd | make_cmd(OP_MOVE, VERT_HDG[b], VERT_SQ[b]);
        horz_cmd = horz_cmd | make_cmd(OP_MOVE_FANFARE, HORZ_HDG[b], HORZ_SQ[b]);
      end
    end
  end

  assign valid = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Arbitrates cmd_proc between the UART and the tour replay: UART passes through when
// idle; after start_tour each solver move is issued as a vertical then a horizontal leg.
module tour_cmd_sequencer
  import knight_pkg::*;
#(
  parameter int NUM_MOVES = NUM_MOVES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_err
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic        tour_err_q, tour_err_d;
  logic [15:0] vert_cmd, horz_cmd;
  logic        move_valid;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .valid    (move_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mv_indx_q  <= 5'd0;
      tour_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      tour_err_q <= tour_err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    tour_err_d       = 1'b0;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = POS_ACK;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = ACK;
        if (start_tour) begin
          mv_indx_d = 5'd0;
          state_d   = VERT;
        end
      end
      VERT: begin
        cmd = vert_cmd;
        // A corrupt move aborts before anything reaches cmd_proc.
        if (!move_valid) begin
          tour_err_d = 1'b1;
          mv_indx_d  = 5'd0;
          state_d    = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = WAIT_V;
        end
      end
      WAIT_V: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        if (send_resp) begin
          if (mv_indx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mv_indx  = mv_indx_q;
  assign tour_err = tour_err_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: a knight-move level model plus a cmd_proc responder,
// checked every cycle, with literal expectations for the directed scenarios.
module tb_tour_cmd_sequencer;

  localparam int NUM = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_tour = 1'b0;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [15:0] cmd_UART = 16'h0000;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic [7:0]  resp;
  logic        tour_err;

  logic [7:0]  move_mem [32];
  logic [7:0]  tour_mv [NUM];
  assign move = move_mem[mv_indx];

  always #5 clk = ~clk;

  tour_cmd_sequencer #(.NUM_MOVES(NUM)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp),
    .tour_err         (tour_err)
  );

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Knight displacement per move bit: north and east positive.
  int dy8 [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  int dx8 [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input int leg);
    int k;
    int d;
    k = -1;
    for (int b = 0; b < 8; b++) if (mv[b]) k = b;
    if (k < 0) return 16'h0000;
    if (leg == 0) begin
      d = dy8[k];
      return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'((d < 0) ? -d : d)};
    end
    d = dx8[k];
    return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'((d < 0) ? -d : d)};
  endfunction

  // Model: tour active flag, current move number, which leg, whether that leg was taken.
  logic m_active = 1'b0;
  logic m_issued = 1'b0;
  logic m_err = 1'b0;
  int   m_idx = 0;
  int   m_leg = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_issued <= 1'b0;
      m_err    <= 1'b0;
      m_idx    <= 0;
      m_leg    <= 0;
    end else begin
      m_err <= 1'b0;
      if (!m_active) begin
        if (start_tour) begin
          m_active <= 1'b1;
          m_idx    <= 0;
          m_leg    <= 0;
          m_issued <= 1'b0;
        end
      end else if (!m_issued) begin
        if (m_leg == 0 && !$onehot(move_mem[m_idx])) begin
          m_err    <= 1'b1;
          m_active <= 1'b0;
          m_idx    <= 0;
        end else if (clr_cmd_rdy) begin
          m_issued <= 1'b1;
        end
      end else if (send_resp) begin
        m_issued <= 1'b0;
        if (m_leg == 0) begin
          m_leg <= 1;
        end else begin
          m_leg <= 0;
          if (m_idx == NUM - 1) m_active <= 1'b0;
          else m_idx <= m_idx + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic exp_rdy;
      chk("mv_indx", 32'(mv_indx), 32'(m_idx));
      chk("resp", 32'(resp), m_active ? 32'hA5 : 32'h5A);
      chk("tour_err", 32'(tour_err), 32'(m_err));
      if (!m_active) begin
        chk("idle_cmd", 32'(cmd), 32'(cmd_UART));
        chk("idle_cmd_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
        chk("idle_clr_uart", 32'(clr_cmd_rdy_UART), 32'(clr_cmd_rdy));
      end else begin
        exp_rdy = !m_issued && !(m_leg == 0 && !$onehot(move_mem[m_idx]));
        chk("tour_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
        chk("tour_cmd_rdy", 32'(cmd_rdy), 32'(exp_rdy));
        if (exp_rdy) chk("tour_cmd", 32'(cmd), 32'(exp_cmd(move_mem[m_idx], m_leg)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_cmds = 0;
  logic [15:0] cmd_log [64];

  task automatic do_leg(output logic [15:0] c, input bit do_resp);
    int n;
    n = 0;
    while (!cmd_rdy && n < 20) begin
      step();
      n++;
    end
    chk("leg_cmd_rdy", 32'(cmd_rdy), 32'd1);
    c = cmd;
    if (n_cmds < 64) cmd_log[n_cmds] = cmd;
    n_cmds++;
    $display("leg mv_indx=%0d cmd=%h", mv_indx, cmd);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    step();
    step();
    if (do_resp) begin
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;
    end
  endtask

  task automatic do_move();
    logic [15:0] c;
    do_leg(c, 1'b1);
    do_leg(c, 1'b1);
  endtask

  task automatic start();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int px [25];
    int py [25];
    int nxt [25];
    int mvk [NUM];
    bit vis [5][5];
    int d, nx, ny, guard, x, y, sq, distinct;
    bit ok;
    logic [15:0] c;

    for (int i = 0; i < 32; i++) move_mem[i] = 8'h00;

    // Find a 5x5 tour from a corner by backtracking.
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) vis[i][j] = 1'b0;
    px[0] = 0; py[0] = 0; vis[0][0] = 1'b1; nxt[0] = 0; d = 0; guard = 0;
    while (d < NUM && d >= 0 && guard < 5000000) begin
      guard++;
      ok = 1'b0;
      for (int k = nxt[d]; k < 8 && !ok; k++) begin
        nx = px[d] + dx8[k];
        ny = py[d] + dy8[k];
        if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5 && !vis[nx][ny]) begin
          ok = 1'b1;
          mvk[d] = k;
          nxt[d] = k + 1;
          px[d+1] = nx;
          py[d+1] = ny;
          vis[nx][ny] = 1'b1;
          nxt[d+1] = 0;
        end
      end
      if (ok) d++;
      else begin
        vis[px[d]][py[d]] = 1'b0;
        d--;
      end
    end
    if (d != NUM) begin
      $display("FAIL tour_search actual=%0d required=%0d", d, NUM);
      $fatal(1, "no tour");
    end
    for (int i = 0; i < NUM; i++) tour_mv[i] = 8'(1 << mvk[i]);

    // Reset state, including pass-through while held in reset.
    #2 rst_n = 1'b0;
    check_en = 1'b1;
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    step();
    chk("rst_mv_indx", 32'(mv_indx), 32'd0);
    chk("rst_tour_err", 32'(tour_err), 32'd0);
    chk("rst_resp", 32'(resp), 32'h5A);
    chk("rst_cmd", 32'(cmd), 32'h1234);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    step();
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    step();

    // Idle pass-through.
    cmd_UART = 16'h2003;
    cmd_rdy_UART = 1'b1;
    step();
    chk("t1_cmd", 32'(cmd), 32'h2003);
    chk("t1_cmd_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1;
    #1 chk("t1_clr_uart_hi", 32'(clr_cmd_rdy_UART), 32'd1);
    step();
    clr_cmd_rdy = 1'b0;
    #1 chk("t1_clr_uart_lo", 32'(clr_cmd_rdy_UART), 32'd0);
    chk("t1_resp", 32'(resp), 32'h5A);
    $display("uart cmd=%h passed through", cmd);
    cmd_rdy_UART = 1'b0;
    step();

    // Single move literal legs, then asynchronous reset while in WAIT_H at move 10.
    for (int i = 0; i < NUM; i++) move_mem[i] = tour_mv[i];
    move_mem[0] = 8'h01;
    start();
    do_leg(c, 1'b1);
    chk("t2_vert", 32'(c), 32'h2002);
    do_leg(c, 1'b0);
    chk("t2_horz", 32'(c), 32'h3BF1);
    chk("t2_resp", 32'(resp), 32'hA5);
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    for (int i = 1; i < 10; i++) do_move();
    do_leg(c, 1'b1);
    do_leg(c, 1'b0);
    chk("t6_pre_idx", 32'(mv_indx), 32'd10);
    cmd_UART = 16'h2BF4;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mv_indx", 32'(mv_indx), 32'd0);
    chk("t6_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("t6_resp", 32'(resp), 32'h5A);
    $display("reset mid-tour mv_indx=%0d", mv_indx);
    step();
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    step();

    // Full tour with board replay of the issued legs.
    for (int i = 0; i < NUM; i++) move_mem[i] = tour_mv[i];
    n_cmds = 0;
    start();
    for (int i = 0; i < NUM; i++) do_move();
    chk("t3_ncmds", 32'(n_cmds), 32'd48);
    chk("t3_end_idx", 32'(mv_indx), 32'd23);
    chk("t3_end_resp", 32'(resp), 32'h5A);
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) vis[i][j] = 1'b0;
    x = 0; y = 0; vis[0][0] = 1'b1; distinct = 1;
    for (int i = 0; i < 48 && i < n_cmds; i++) begin
      sq = int'(cmd_log[i][3:0]);
      case (cmd_log[i][11:4])
        8'h00:   y = y + sq;
        8'h7F:   y = y - sq;
        8'hBF:   x = x + sq;
        default: x = x - sq;
      endcase
      if (i % 2 == 1 && x >= 0 && x < 5 && y >= 0 && y < 5 && !vis[x][y]) begin
        vis[x][y] = 1'b1;
        distinct++;
      end
    end
    chk("t3_squares", 32'(distinct), 32'd25);
    $display("tour done cmds=%0d squares=%0d", n_cmds, distinct);
    step();

    // Bad move at index 5 with a UART command waiting during the tour.
    for (int i = 0; i < NUM; i++) move_mem[i] = tour_mv[i];
    move_mem[5] = 8'h03;
    start();
    do_move();
    cmd_UART = 16'h2BF4;
    cmd_rdy_UART = 1'b1;
    for (int i = 1; i < 5; i++) do_move();
    chk("t5_idx5", 32'(mv_indx), 32'd5);
    chk("t5_no_cmd", 32'(cmd_rdy), 32'd0);
    chk("t4_clr_uart_held", 32'(clr_cmd_rdy_UART), 32'd0);
    step();
    chk("t5_tour_err", 32'(tour_err), 32'd1);
    chk("t5_mv_indx", 32'(mv_indx), 32'd0);
    chk("t5_resp", 32'(resp), 32'h5A);
    $display("bad move aborted tour_err=%0d", tour_err);
    step();
    chk("t5_err_pulse", 32'(tour_err), 32'd0);
    chk("t4_cmd", 32'(cmd), 32'h2BF4);
    clr_cmd_rdy = 1'b1;
    #1 chk("t4_clr_uart", 32'(clr_cmd_rdy_UART), 32'd1);
    step();
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;
    $display("uart cmd=%h passed through after tour", cmd_UART);
    step();
    step();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
